// File: rtl/sync_fifo_write_arbiter_pkg.sv
// Shared definitions for the sync_fifo write-port arbiter and its helpers.
package sync_fifo_write_arbiter_pkg;

    typedef enum logic {
        STATE_IDLE   = 1'b0,
        STATE_LOCKED = 1'b1
    } state_t;

    localparam int DEFAULT_MAX_BURST = 16;

    // Width needed to hold an index in 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int w = 1; w < 31; w++) begin
            if ((1 << w) < value) begin
                width = w + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/sync_fifo_write_arbiter_picker.sv
// Combinational rotating-priority search: returns the first asserted request
// strictly after pointer, wrapping modulo NUM_REQ (pointer itself is searched last).
module rr_priority_picker
    import sync_fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        found    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand     = (int'(pointer) + k) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (req[cand_idx]) begin
                found = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/sync_fifo_write_arbiter.sv
// Round-robin owner of the sync_fifo write port; a grant lasts a whole packet
// or until MAX_BURST words, and a one-cycle idle bubble separates grants.
module sync_fifo_write_arbiter
    import sync_fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST,
    parameter int IDX_W      = clog2(NUM_REQ)
) (
    input  logic                          comm_clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_in_valid,
    input  logic                          fifo_in_ready,
    output logic [DATA_WIDTH-1:0]         fifo_in_data,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_index
);

    localparam logic [7:0] BURST_FINAL = 8'(MAX_BURST - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] rr_pointer;
    logic [7:0]       burst_count;
    logic             pick_found;
    logic [IDX_W-1:0] pick_index;
    logic             transfer;
    logic             release_grant;

    // Saturating increment for the 8-bit burst counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req_valid),
        .pointer (rr_pointer),
        .found   (pick_found),
        .index   (pick_index)
    );

    assign transfer      = (state == STATE_LOCKED) && req_valid[grant_index] && fifo_in_ready;
    assign release_grant = transfer && (req_last[grant_index] || (burst_count == BURST_FINAL));
    assign grant_valid   = (state == STATE_LOCKED);

    // State register.
    always_ff @(posedge comm_clock or negedge reset) begin
        if (!reset) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: lock onto a winner from IDLE, drop back to IDLE on the closing transfer.
    always_comb begin
        state_next = state;
        case (state)
            STATE_IDLE:   if (pick_found)    state_next = STATE_LOCKED;
            STATE_LOCKED: if (release_grant) state_next = STATE_IDLE;
            default:                         state_next = STATE_IDLE;
        endcase
    end

    // Owner, rotation pointer and burst length bookkeeping.
    always_ff @(posedge comm_clock or negedge reset) begin
        if (!reset) begin
            grant_index <= '0;
            rr_pointer  <= IDX_W'(NUM_REQ - 1);
            burst_count <= 8'd0;
        end else if ((state == STATE_IDLE) && pick_found) begin
            grant_index <= pick_index;
            rr_pointer  <= pick_index;
            burst_count <= 8'd0;
        end else if (release_grant) begin
            burst_count <= 8'd0;
        end else if (transfer) begin
            burst_count <= sat_inc(burst_count);
        end
    end

    // Zero-latency steering of the owner's handshake and data onto the FIFO port.
    always_comb begin
        fifo_in_valid = 1'b0;
        fifo_in_data  = '0;
        req_ready     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_index == IDX_W'(i)) begin
                fifo_in_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (state == STATE_LOCKED) begin
            fifo_in_valid            = req_valid[grant_index];
            req_ready[grant_index]   = fifo_in_ready;
        end
    end

endmodule

// File: doc/sync_fifo_write_arbiter.md
Name: sync_fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of a sync_fifo between NUM_REQ byte producers (e.g. command decoder, status reporter, debug tap), all on comm_clock. A grant is held for a whole packet, so packets from different requesters never interleave in the FIFO. A burst limit caps how long one requester can hold the port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, width of each requester's data word and of the FIFO data word
MAX_BURST, 16, maximum words per grant before forced release (1..255)

Ports:
comm_clock  input  1  single clock; all logic is rising-edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester word valid
req_last  input  NUM_REQ  per-requester marker for the final word of a packet
req_data  input  NUM_REQ*DATA_WIDTH  requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester accept
fifo_in_valid  output  1  to the sync_fifo in_valid
fifo_in_ready  input  1  from the sync_fifo in_ready
fifo_in_data  output  DATA_WIDTH  to the sync_fifo in_data
grant_valid  output  1  a requester currently owns the port
grant_index  output  clog2(NUM_REQ)  index of the owner (meaningful only when grant_valid=1)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, grant_valid=0, grant_index=0, burst_count=0, rr_pointer=NUM_REQ-1. Combinationally, fifo_in_valid=0 and req_ready=0.
- States:
  - IDLE: no owner.
  - LOCKED: grant_index owns the port.
- IDLE -> LOCKED:
  - Occurs on a rising edge where any req_valid=1.
  - New owner = first asserted requester searching rr_pointer+1, rr_pointer+2, ... modulo NUM_REQ.
  - Registered: grant_valid=1, grant_index=owner, rr_pointer=owner, burst_count=0.
- Arbitration latency: 1 cycle. A word is never accepted in the cycle its request is first seen from IDLE.
- Datapath in LOCKED (combinational, zero latency):
  - fifo_in_valid = req_valid[grant_index].
  - fifo_in_data = req_data slice [grant_index].
  - req_ready[grant_index] = fifo_in_ready.
  - req_ready of every other requester = 0.
- Transfer = LOCKED and req_valid[g] and fifo_in_ready. On each transfer, burst_count increments; it is a saturating 8-bit counter.
- LOCKED -> IDLE occurs on a transfer where req_last[g]=1, or where burst_count==MAX_BURST-1.
  - On that edge: grant_valid=0 and burst_count=0.
  - The next grant starts one cycle later. The bubble cycle is required.
- Forced release (burst limit reached without last): the released requester competes again in round-robin order starting after itself. Any other pending requester therefore wins first.
- Owner drops req_valid while LOCKED: the grant is held and nothing is written. There is no timeout.
- FIFO full (fifo_in_ready=0): the grant is held. req_data and req_valid of the owner must be held stable by the requester (standard valid/ready rule). The arbiter does not register data.
- req_last is sampled only together with a transfer; req_last without valid is ignored.
- Simultaneous requests from IDLE: the rotating priority above resolves them; no requester waits more than NUM_REQ-1 grants.
- Reset asserted mid-packet: immediate return to the reset state. The partial packet already in the FIFO is not removed; flushing is the system's responsibility.

Decomposition:
- Shared package holds:
  - the state encoding constants (STATE_IDLE, STATE_LOCKED);
  - a grant-index width helper (clog2 function);
  - the default MAX_BURST constant.
- One natural sub-module: rr_priority_picker. It is combinational: inputs are the request vector and rr_pointer; outputs are found and index. It is reused later for a read-side scheduler.

Test Plan:
1. Reset held low 4 cycles, then released, with no requests -> grant_valid=0, fifo_in_valid=0, req_ready=0000 throughout.
2. Only req 1 sends 8'hA1, 8'hA2 (last=1 on the 2nd) -> grant_index=1 one cycle after valid. The FIFO receives A1, A2 in order. grant_valid drops after A2.
3. Reqs 0 and 2 each hold a 3-word packet starting in the same cycle -> all 3 of req 0's words are written first (rr_pointer starts at 3). Then one idle cycle. Then all 3 of req 2's words. No interleaving.
4. Req 3 streams 20 words with no last, MAX_BURST=16, and req 0 is pending -> exactly 16 words from req 3. Then a 1-cycle bubble. Then req 0 is granted.
5. Hold fifo_in_ready=0 for 5 cycles mid-packet from req 2 (data 8'h55) -> req_ready[2]=0 during the stall and the grant is held. 8'h55 is written on the first ready cycle, exactly once.
6. Assert reset mid-packet on req 1's second of 4 words -> outputs are at reset values within the same cycle. After release, req 1 must be re-arbitrated with the 1-cycle latency.
